rf_wport_arbiter: RTL and testbench



---
 rtl/rf_wport_arbiter_pkg.sv | 22 ++
 rtl/rf_wport_arbiter_if.sv | 44 ++++
 rtl/rf_idx_decoder.sv | 22 ++
 rtl/rf_wport_arbiter.sv | 101 ++++++++++
 tb/tb_rf_wport_arbiter.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/rf_wport_arbiter_pkg.sv
// rtl/rf_wport_arbiter_pkg.sv - shared constants and types for the register-file write-port arbiter
// Purpose: register-file geometry, the writeback request record and the grant encoding.
package rf_wport_arbiter_pkg;

  localparam int DATA_W   = 16;
  localparam int NUM_REGS = 8;
  localparam int IDX_W    = 3;

  // One writeback request as presented by a requester.
  typedef struct packed {
    logic              valid;
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] data;
  } wreq_t;

  // Which requester a grant refers to; also the encoding of last_grant.
  typedef enum logic {
    GRANT_REQ0 = 1'b0,
    GRANT_REQ1 = 1'b1
  } grant_e;

endpackage

// File: rtl/rf_wport_arbiter_if.sv
// rtl/rf_wport_arbiter_if.sv - write-port bundle between the writeback requesters and the arbiter
// Purpose: groups both requester handshakes, the stall input and the commit/pending outputs.
// Ports (slave = arbiter side):
//   req0_valid/idx/data in, req0_ready out   ALU/execute writeback
//   req1_valid/idx/data in, req1_ready out   memory/multi-cycle writeback
//   wr_stall in                              register file cannot commit this cycle
//   wr_en/wr_data out                        one-hot register enable and shared data
//   pend_valid/pend_idx out                  uncommitted write, for decode hazard checks
interface rf_wport_arbiter_if;
  import rf_wport_arbiter_pkg::*;

  logic                req0_valid;
  logic [IDX_W-1:0]    req0_idx;
  logic [DATA_W-1:0]   req0_data;
  logic                req0_ready;
  logic                req1_valid;
  logic [IDX_W-1:0]    req1_idx;
  logic [DATA_W-1:0]   req1_data;
  logic                req1_ready;
  logic                wr_stall;
  logic [NUM_REGS-1:0] wr_en;
  logic [DATA_W-1:0]   wr_data;
  logic                pend_valid;
  logic [IDX_W-1:0]    pend_idx;

  modport master (
    output req0_valid, req0_idx, req0_data,
    input  req0_ready,
    output req1_valid, req1_idx, req1_data,
    input  req1_ready,
    output wr_stall,
    input  wr_en, wr_data, pend_valid, pend_idx
  );

  modport slave (
    input  req0_valid, req0_idx, req0_data,
    output req0_ready,
    input  req1_valid, req1_idx, req1_data,
    output req1_ready,
    input  wr_stall,
    output wr_en, wr_data, pend_valid, pend_idx
  );

endinterface

// File: rtl/rf_idx_decoder.sv
// rtl/rf_idx_decoder.sv - enable-gated register index to one-hot decoder
// Purpose: turns a register index into a one-hot select; all-zero when en is low.
// Ports: en (decode enable), idx (register index), onehot (NUM_REGS-wide select).
module rf_idx_decoder #(
  parameter int IDX_W    = rf_wport_arbiter_pkg::IDX_W,
  parameter int NUM_REGS = rf_wport_arbiter_pkg::NUM_REGS
) (
  input  logic                en,
  input  logic [IDX_W-1:0]    idx,
  output logic [NUM_REGS-1:0] onehot
);

  // NUM_REGS == 2**IDX_W, so every idx selects a real register and the
  // result is never multi-hot.
  always_comb begin
    onehot = '0;
    if (en) begin
      onehot[idx] = 1'b1;
    end
  end

endmodule

// File: rtl/rf_wport_arbiter.sv
// rtl/rf_wport_arbiter.sv - round-robin arbiter sharing the register-file write port
// Purpose: picks one of two writeback requesters each cycle, registers the winner in a
//   one-entry output stage and commits it to the register file unless stalled.
// Ports:
//   clk  system clock
//   rst  asynchronous active-high reset
//   wp   write-port bundle (slave side): requester handshakes in/out, wr_stall in,
//        wr_en/wr_data commit and pend_valid/pend_idx hazard outputs
module rf_wport_arbiter
  import rf_wport_arbiter_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  rf_wport_arbiter_if.slave wp
);

  wreq_t               req0;
  wreq_t               req1;
  grant_e              grant;
  logic                any_valid;
  logic                can_load;
  logic                commit;
  logic                xfer;
  logic [IDX_W-1:0]    win_idx;
  logic [DATA_W-1:0]   win_data;
  logic [NUM_REGS-1:0] wr_en_dec;

  logic                out_valid_d, out_valid_q;
  logic [IDX_W-1:0]    out_idx_d,   out_idx_q;
  logic [DATA_W-1:0]   out_data_d,  out_data_q;
  grant_e              last_grant_d, last_grant_q;

  always_comb begin
    req0 = '{valid: wp.req0_valid, idx: wp.req0_idx, data: wp.req0_data};
    req1 = '{valid: wp.req1_valid, idx: wp.req1_idx, data: wp.req1_data};

    commit    = out_valid_q & ~wp.wr_stall;
    // The stage may refill in the same cycle its current entry commits.
    can_load  = ~out_valid_q | ~wp.wr_stall;
    any_valid = req0.valid | req1.valid;

    if (req0.valid && req1.valid) begin
      grant = (last_grant_q == GRANT_REQ0) ? GRANT_REQ1 : GRANT_REQ0;
    end else if (req1.valid) begin
      grant = GRANT_REQ1;
    end else begin
      grant = GRANT_REQ0;
    end

    win_idx  = (grant == GRANT_REQ1) ? req1.idx  : req0.idx;
    win_data = (grant == GRANT_REQ1) ? req1.data : req0.data;

    // Nothing is acknowledged while reset holds the stage empty.
    xfer = can_load & any_valid & ~rst;

    out_valid_d  = out_valid_q;
    out_idx_d    = out_idx_q;
    out_data_d   = out_data_q;
    last_grant_d = last_grant_q;
    if (xfer) begin
      out_valid_d  = 1'b1;
      out_idx_d    = win_idx;
      out_data_d   = win_data;
      last_grant_d = grant;
    end else if (commit) begin
      out_valid_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      out_idx_q    <= '0;
      out_data_q   <= '0;
      // Requester 0 wins the first contention after reset.
      last_grant_q <= GRANT_REQ1;
    end else begin
      out_valid_q  <= out_valid_d;
      out_idx_q    <= out_idx_d;
      out_data_q   <= out_data_d;
      last_grant_q <= last_grant_d;
    end
  end

  rf_idx_decoder #(
    .IDX_W    (IDX_W),
    .NUM_REGS (NUM_REGS)
  ) u_wr_dec (
    .en     (commit),
    .idx    (out_idx_q),
    .onehot (wr_en_dec)
  );

  assign wp.req0_ready = xfer & (grant == GRANT_REQ0);
  assign wp.req1_ready = xfer & (grant == GRANT_REQ1);
  assign wp.wr_en      = wr_en_dec;
  assign wp.wr_data    = out_data_q;
  assign wp.pend_valid = out_valid_q;
  assign wp.pend_idx   = out_idx_q;

endmodule

// File: tb/tb_rf_wport_arbiter.sv
// tb/tb_rf_wport_arbiter.sv - self-checking bench for the register-file write-port arbiter
module tb_rf_wport_arbiter;
  import rf_wport_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rf_wport_arbiter_if wp();

  rf_wport_arbiter dut (
    .clk (clk),
    .rst (rst),
    .wp  (wp)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: FIFO of accepted-but-uncommitted writes (at most one),
  // who was served last, and the architectural register contents.
  typedef struct {
    int idx;
    int data;
  } wr_t;

  wr_t               pend_q[$];
  int                last_served = 1;
  int                ref_rf[NUM_REGS];
  logic [DATA_W-1:0] obs_rf[NUM_REGS];

  // Observations from the most recent step.
  int                  last_win;
  logic [NUM_REGS-1:0] obs_en;
  logic [DATA_W-1:0]   obs_data;
  logic [IDX_W-1:0]    obs_pidx;

  // One clock: check outputs at the falling edge against the model,
  // then advance the model across the rising edge. Returns at posedge+1.
  task automatic step();
    int                  win;
    bit                  commit;
    bit                  space;
    logic [NUM_REGS-1:0] exp_en;
    wr_t                 w;
    @(negedge clk);
    commit = (pend_q.size() != 0) && !wp.wr_stall;
    space  = (pend_q.size() == 0) || !wp.wr_stall;
    win    = -1;
    if (space) begin
      if (wp.req0_valid && wp.req1_valid) win = 1 - last_served;
      else if (wp.req0_valid)             win = 0;
      else if (wp.req1_valid)             win = 1;
    end
    exp_en = '0;
    if (commit) exp_en[pend_q[0].idx] = 1'b1;

    check("req0_ready", 32'(wp.req0_ready), 32'(win == 0));
    check("req1_ready", 32'(wp.req1_ready), 32'(win == 1));
    check("wr_en", 32'(wp.wr_en), 32'(exp_en));
    check("pend_valid", 32'(wp.pend_valid), 32'(pend_q.size() != 0));
    if (pend_q.size() != 0) begin
      check("pend_idx", 32'(wp.pend_idx), 32'(pend_q[0].idx));
      check("wr_data", 32'(wp.wr_data), 32'(pend_q[0].data));
    end

    obs_en   = wp.wr_en;
    obs_data = wp.wr_data;
    obs_pidx = wp.pend_idx;
    last_win = win;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (wp.wr_en[k]) obs_rf[k] = wp.wr_data;
    end

    if (commit) begin
      ref_rf[pend_q[0].idx] = pend_q[0].data;
      void'(pend_q.pop_front());
    end
    if (win == 0) begin
      w.idx = int'(wp.req0_idx); w.data = int'(wp.req0_data);
      pend_q.push_back(w);
      last_served = 0;
    end else if (win == 1) begin
      w.idx = int'(wp.req1_idx); w.data = int'(wp.req1_data);
      pend_q.push_back(w);
      last_served = 1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int n, input logic v, input int idx, input int data);
    if (n == 0) begin
      wp.req0_valid = v; wp.req0_idx = IDX_W'(idx); wp.req0_data = DATA_W'(data);
    end else begin
      wp.req1_valid = v; wp.req1_idx = IDX_W'(idx); wp.req1_data = DATA_W'(data);
    end
  endtask

  // Requesters hold a request until it is accepted, then may issue another.
  task automatic drive_random();
    if (!wp.req0_valid || last_win == 0)
      set_req(0, ($urandom_range(0, 99) < 60), $urandom_range(0, NUM_REGS - 1), $urandom_range(0, 16'hFFFF));
    if (!wp.req1_valid || last_win == 1)
      set_req(1, ($urandom_range(0, 99) < 60), $urandom_range(0, NUM_REGS - 1), $urandom_range(0, 16'hFFFF));
    wp.wr_stall = ($urandom_range(0, 99) < 30);
  endtask

  int wins[4];

  initial begin
    for (int k = 0; k < NUM_REGS; k++) begin
      ref_rf[k] = 0;
      obs_rf[k] = '0;
    end
    rst = 1'b1;
    wp.wr_stall = 1'b0;
    set_req(0, 1'b1, 1, 16'h1111);
    set_req(1, 1'b1, 2, 16'h2222);

    // Reset holds everything quiet even with both requests valid.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_wr_en", 32'(wp.wr_en), 32'h0);
    check("rst_req0_ready", 32'(wp.req0_ready), 32'h0);
    check("rst_req1_ready", 32'(wp.req1_ready), 32'h0);
    check("rst_pend_valid", 32'(wp.pend_valid), 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;

    step();
    check("first_grant", 32'(last_win), 32'd0);
    set_req(0, 1'b0, 0, 0);
    step();
    set_req(1, 1'b0, 0, 0);
    step();

    // Single requester.
    set_req(0, 1'b1, 3, 16'hBEEF);
    step();
    check("single_accept", 32'(last_win), 32'd0);
    set_req(0, 1'b0, 0, 0);
    step();
    check("single_wr_en", 32'(obs_en), 32'h08);
    check("single_wr_data", 32'(obs_data), 32'hBEEF);

    // Make requester 1 the last served, then contend for four cycles.
    set_req(1, 1'b1, 0, 16'h0000);
    step();
    set_req(0, 1'b1, 1, 16'h1111);
    set_req(1, 1'b1, 2, 16'h2222);
    for (int i = 0; i < 4; i++) begin
      step();
      wins[i] = last_win;
      if (i == 2) check("rr_wr_en_2", 32'(obs_en), 32'h04);
      if (i == 3) check("rr_wr_en_3", 32'(obs_en), 32'h02);
    end
    check("rr_seq", {wins[0][7:0], wins[1][7:0], wins[2][7:0], wins[3][7:0]}, 32'h00010001);
    set_req(0, 1'b0, 0, 0);
    set_req(1, 1'b0, 0, 0);
    step();
    check("rr_drain_wr_en", 32'(obs_en), 32'h04);

    // Back-pressure on a pending write to register 5.
    set_req(0, 1'b1, 5, 16'h0505);
    step();
    set_req(0, 1'b0, 0, 0);
    set_req(1, 1'b1, 6, 16'h0606);
    wp.wr_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_wr_en", 32'(obs_en), 32'h0);
      check("stall_pend_idx", 32'(obs_pidx), 32'd5);
      check("stall_no_grant", 32'(last_win), 32'hFFFFFFFF);
    end
    wp.wr_stall = 1'b0;
    step();
    check("unstall_wr_en", 32'(obs_en), 32'h20);
    check("unstall_accept", 32'(last_win), 32'd1);
    set_req(1, 1'b0, 0, 0);

    // Same destination register from both requesters.
    set_req(0, 1'b1, 7, 16'hAAAA);
    set_req(1, 1'b1, 7, 16'h5555);
    step();
    check("same_first", 32'(last_win), 32'd0);
    set_req(0, 1'b0, 0, 0);
    step();
    check("same_second", 32'(last_win), 32'd1);
    check("same_commit1", 32'(obs_data), 32'hAAAA);
    set_req(1, 1'b0, 0, 0);
    step();
    check("same_commit2", 32'(obs_data), 32'h5555);
    check("same_final_reg", 32'(obs_rf[7]), 32'h5555);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      drive_random();
      step();
    end
    set_req(0, 1'b0, 0, 0);
    set_req(1, 1'b0, 0, 0);
    wp.wr_stall = 1'b0;
    step();

    // Asynchronous reset between edges with a write pending; req0 was served last.
    set_req(0, 1'b1, 4, 16'h0404);
    wp.wr_stall = 1'b1;
    step();
    set_req(0, 1'b0, 0, 0);
    step();
    wp.wr_stall = 1'b0;
    #1;
    check("pre_rst_pend", 32'(wp.pend_valid), 32'h1);
    check("pre_rst_wr_en", 32'(wp.wr_en), 32'h10);
    rst = 1'b1;
    #1;
    check("async_rst_pend", 32'(wp.pend_valid), 32'h0);
    check("async_rst_wr_en", 32'(wp.wr_en), 32'h0);
    #1 rst = 1'b0;
    pend_q.delete();
    last_served = 1;
    set_req(0, 1'b1, 2, 16'h0202);
    set_req(1, 1'b1, 3, 16'h0303);
    step();
    check("post_rst_grant", 32'(last_win), 32'd0);
    set_req(0, 1'b0, 0, 0);
    step();
    set_req(1, 1'b0, 0, 0);
    step();
    step();

    for (int k = 0; k < NUM_REGS; k++) begin
      check($sformatf("reg%0d", k), 32'(obs_rf[k]), 32'(ref_rf[k]));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
